// File: rtl/ren_conv_job_sequencer_if.sv
// Wishbone bus bundle between the job sequencer and the conv wrapper.
// Master drives cyc/stb/we/sel/adr/dat_o; slave returns dat_i and ack.
interface ren_conv_job_sequencer_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o,
    output m_sel_o, m_adr_o, m_dat_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o,
    input  m_sel_o, m_adr_o, m_dat_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/ren_conv_job_sequencer.sv
// Runs queued conv jobs on ren_conv_top instances over Wishbone.
// Ports: clk/rst, job push (valid/ready/inst/cfg1/cfg2), busy, report, bus m.
module ren_conv_job_sequencer #(
  parameter int          NO_OF_INSTS   = 4,
  parameter int          JOB_DEPTH     = 4,
  parameter logic [31:0] REG_BASE_ADDR = 32'h3000_0000,
  parameter int          POLL_GAP      = 10,
  parameter int          MAX_POLLS     = 100,
  localparam int INST_W = (NO_OF_INSTS > 1) ? $clog2(NO_OF_INSTS) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [INST_W-1:0] job_inst_i,
  input  logic [31:0]       job_cfg1_i,
  input  logic [31:0]       job_cfg2_i,
  output logic              busy_o,
  output logic              rpt_valid_o,
  output logic [INST_W-1:0] rpt_inst_o,
  output logic              rpt_err_o,
  ren_conv_job_sequencer_if.master m
);

  localparam int PTR_W = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PW    = $clog2(MAX_POLLS + 1);
  localparam int GW    = $clog2(POLL_GAP + 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       cfg1;
    logic [31:0]       cfg2;
  } job_t;

  typedef enum logic [3:0] {
    IDLE, WR_CFG1, WR_CFG2, WR_START,
    POLL_WAIT, POLL_RD, CLR_START,
    SRST_SET, SRST_CLR, REPORT
  } state_e;

  job_t             mem_q [JOB_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop;

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       cfg1_q, cfg1_d;
  logic [31:0]       cfg2_q, cfg2_d;
  logic              err_q, err_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;

  logic        ack_w;
  logic        bus_req;
  logic        req_we;
  logic [31:0] req_off;
  logic [31:0] req_dat;
  logic [31:0] base;
  state_e      nxt;

  assign job_ready_o = (cnt_q != CNT_W'(JOB_DEPTH));
  assign push        = job_valid_i & job_ready_o;
  assign pop         = (state_q == IDLE) & (cnt_q != '0);
  assign ack_w       = cyc_q & m.m_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_q] <= '{inst: job_inst_i,
                       cfg1: job_cfg1_i,
                       cfg2: job_cfg2_i};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cfg1_d  = cfg1_q;
    cfg2_d  = cfg2_q;
    err_d   = err_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    bus_req = 1'b0;
    req_we  = 1'b1;
    req_off = 32'h0;
    req_dat = 32'h0;
    nxt     = state_q;
    base    = REG_BASE_ADDR + (32'(inst_q) << 24);

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          inst_d  = mem_q[rd_q].inst;
          cfg1_d  = mem_q[rd_q].cfg1;
          cfg2_d  = mem_q[rd_q].cfg2;
          err_d   = 1'b0;
          state_d = WR_CFG1;
        end
      end
      WR_CFG1: begin
        bus_req = 1'b1;
        req_off = 32'h4;
        req_dat = cfg1_q;
        nxt     = WR_CFG2;
      end
      WR_CFG2: begin
        bus_req = 1'b1;
        req_off = 32'h8;
        req_dat = cfg2_q;
        nxt     = WR_START;
      end
      WR_START: begin
        bus_req = 1'b1;
        req_dat = 32'h4;
        nxt     = POLL_WAIT;
        if (ack_w) begin
          poll_d = '0;
          gap_d  = '0;
        end
      end
      POLL_WAIT: begin
        if (gap_q == GW'(POLL_GAP - 1)) begin
          gap_d   = '0;
          state_d = POLL_RD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      POLL_RD: begin
        bus_req = 1'b1;
        req_we  = 1'b0;
        if (m.m_dat_i[0]) begin
          nxt = CLR_START;
        end else if (poll_q == PW'(MAX_POLLS - 1)) begin
          nxt = CLR_START;
        end else begin
          nxt = POLL_WAIT;
        end
        if (ack_w) begin
          poll_d = poll_q + PW'(1);
          err_d  = ~m.m_dat_i[0] &
                   (poll_q == PW'(MAX_POLLS - 1));
        end
      end
      CLR_START: begin
        bus_req = 1'b1;
        nxt     = SRST_SET;
      end
      SRST_SET: begin
        bus_req = 1'b1;
        req_dat = 32'h2;
        nxt     = SRST_CLR;
      end
      SRST_CLR: begin
        bus_req = 1'b1;
        nxt     = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Launch from idle bus; the ack edge both ends the cycle and
    // advances the FSM, so the next launch is one idle cycle later.
    if (bus_req) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = req_we;
        sel_d = 4'hf;
        adr_d = base + req_off;
        dat_d = req_dat;
      end else if (m.m_ack_i) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = 4'h0;
        adr_d   = 32'h0;
        dat_d   = 32'h0;
        state_d = nxt;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      inst_q  <= '0;
      cfg1_q  <= '0;
      cfg2_q  <= '0;
      err_q   <= 1'b0;
      gap_q   <= '0;
      poll_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cfg1_q  <= cfg1_d;
      cfg2_q  <= cfg2_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign m.m_cyc_o = cyc_q;
  assign m.m_stb_o = cyc_q;
  assign m.m_we_o  = we_q;
  assign m.m_sel_o = sel_q;
  assign m.m_adr_o = adr_q;
  assign m.m_dat_o = dat_q;

  assign busy_o      = (state_q != IDLE) | (cnt_q != '0);
  assign rpt_valid_o = (state_q == REPORT);
  assign rpt_inst_o  = rpt_valid_o ? inst_q : '0;
  assign rpt_err_o   = rpt_valid_o & err_q;

endmodule

// File: tb/tb_ren_conv_job_sequencer.sv
// Directed bench for ren_conv_job_sequencer: vector table of jobs
// plus back-pressure, random ack delay and mid-job reset sequences.
module tb_ren_conv_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [1:0]  job_inst = '0;
  logic [31:0] cfg1 = '0;
  logic [31:0] cfg2 = '0;
  logic        busy;
  logic        rpt_valid;
  logic [1:0]  rpt_inst;
  logic        rpt_err;

  always #5 clk = ~clk;

  ren_conv_job_sequencer_if bus();

  ren_conv_job_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .job_valid_i (job_valid),
    .job_ready_o (job_ready),
    .job_inst_i  (job_inst),
    .job_cfg1_i  (cfg1),
    .job_cfg2_i  (cfg2),
    .busy_o      (busy),
    .rpt_valid_o (rpt_valid),
    .rpt_inst_o  (rpt_inst),
    .rpt_err_o   (rpt_err),
    .m           (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: acks after 0..s_delay_max cycles, returns done
  // on the s_done_after-th read since the last start write.
  bit          s_stall = 1'b0;
  int unsigned s_delay_max = 0;
  int          s_done_after = 0;
  int          s_rd_cnt = 0;
  int unsigned wcnt = 0;
  int unsigned cur_delay = 0;
  logic [64:0] log_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.m_ack_i <= 1'b0;
      bus.m_dat_i <= 32'h0;
      wcnt        <= 0;
    end else if (bus.m_ack_i) begin
      bus.m_ack_i <= 1'b0;
    end else if (bus.m_cyc_o && bus.m_stb_o && !s_stall) begin
      if (wcnt >= cur_delay) begin
        bus.m_ack_i <= 1'b1;
        wcnt        <= 0;
        cur_delay   <= $urandom_range(s_delay_max, 0);
        if (bus.m_we_o) begin
          log_q.push_back({1'b1, bus.m_adr_o, bus.m_dat_o});
          if (bus.m_adr_o[23:0] == 24'h0 && bus.m_dat_o == 32'h4)
            s_rd_cnt <= 0;
          bus.m_dat_i <= 32'h0;
        end else begin
          log_q.push_back({1'b0, bus.m_adr_o, 32'h0});
          s_rd_cnt <= s_rd_cnt + 1;
          bus.m_dat_i <= (s_done_after != 0 &&
                          s_rd_cnt + 1 >= s_done_after) ?
                         32'h1 : 32'h0;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Bus protocol monitor
  logic        p_cyc = 1'b0;
  logic        p_ack = 1'b0;
  logic [64:0] p_tr = '0;
  int          bus_viol = 0;

  always @(negedge clk) begin
    if (bus.m_cyc_o !== bus.m_stb_o) bus_viol++;
    if (bus.m_cyc_o && bus.m_sel_o !== 4'hf) bus_viol++;
    if (!bus.m_cyc_o &&
        {bus.m_we_o, bus.m_sel_o, bus.m_adr_o, bus.m_dat_o} !== '0)
      bus_viol++;
    if (p_ack && bus.m_cyc_o) bus_viol++;
    if (p_cyc && bus.m_cyc_o && !p_ack &&
        {bus.m_we_o, bus.m_adr_o, bus.m_dat_o} !== p_tr)
      bus_viol++;
    p_cyc = bus.m_cyc_o;
    p_ack = bus.m_ack_i;
    p_tr  = {bus.m_we_o, bus.m_adr_o, bus.m_dat_o};
  end

  logic [2:0] rpt_q[$];
  always @(negedge clk) begin
    if (rpt_valid === 1'b1) rpt_q.push_back({rpt_err, rpt_inst});
  end

  typedef struct {
    logic [1:0]  inst;
    logic [31:0] c1;
    logic [31:0] c2;
    int          done_after;
    int unsigned dly;
    logic        err;
    int          reads;
  } vec_t;

  vec_t vecs[5];

  task automatic push(input logic [1:0] i,
                      input logic [31:0] c1,
                      input logic [31:0] c2);
    int n = 0;
    @(negedge clk);
    job_valid = 1'b1;
    job_inst  = i;
    cfg1      = c1;
    cfg2      = c2;
    while (!job_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", job_ready, 1'b1);
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [64:0] exp_q[$];
    logic [31:0] b;
    logic [2:0]  r;
    int n = 0;
    int bad = -1;
    log_q.delete();
    rpt_q.delete();
    s_done_after = v.done_after;
    s_delay_max  = v.dly;
    b = 32'h3000_0000 + (32'(v.inst) << 24);
    exp_q.push_back({1'b1, b + 32'h4, v.c1});
    exp_q.push_back({1'b1, b + 32'h8, v.c2});
    exp_q.push_back({1'b1, b, 32'h4});
    repeat (v.reads) exp_q.push_back({1'b0, b, 32'h0});
    exp_q.push_back({1'b1, b, 32'h0});
    exp_q.push_back({1'b1, b, 32'h2});
    exp_q.push_back({1'b1, b, 32'h0});
    push(v.inst, v.c1, v.c2);
    while (rpt_q.size() == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rpt_seen", rpt_q.size(), 1);
    r = (rpt_q.size() != 0) ? rpt_q[0] : 3'bxxx;
    chk("rpt_err_inst", r, {v.err, v.inst});
    repeat (2) @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("trace_len", log_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i]))
        bad = i;
    end
    chk("trace_first_bad_idx", bad, -1);
  endtask

  logic [1:0] bp_ids[6];

  initial begin
    int n;
    logic [2:0] r;

    vecs[0] = '{2'd1, 32'h0100_5401, 32'h001E_002A, 3, 0, 1'b0, 3};
    vecs[1] = '{2'd0, 32'h0200_3702, 32'h0004_0310, 1, 0, 1'b0, 1};
    vecs[2] = '{2'd3, 32'h0101_1F02, 32'h0023_0120, 5, 3, 1'b0, 5};
    vecs[3] = '{2'd2, 32'h0100_0000, 32'h0000_0005, 0, 0, 1'b1, 100};
    vecs[4] = '{2'd1, 32'h0300_2203, 32'h000C_0404, 2, 3, 1'b0, 2};

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus",
        {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_sel_o,
         bus.m_adr_o, bus.m_dat_o}, '0);
    chk("rst_ready", job_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rpt", rpt_valid, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: one job stuck in flight, fill FIFO behind it
    log_q.delete();
    rpt_q.delete();
    s_done_after = 1;
    s_delay_max  = 0;
    s_stall      = 1'b1;
    bp_ids = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    push(2'd2, 32'h1, 32'h2);
    repeat (3) @(negedge clk);
    chk("bp_inflight", {bus.m_cyc_o, busy}, 2'b11);
    for (int i = 1; i < 5; i++) push(bp_ids[i], 32'h10 + i, 32'h20 + i);
    @(negedge clk);
    chk("bp_full_ready", job_ready, 1'b0);
    job_valid = 1'b1;
    job_inst  = 2'd0;
    repeat (3) @(negedge clk);
    chk("bp_still_full", job_ready, 1'b0);
    job_valid = 1'b0;
    s_stall   = 1'b0;
    push(bp_ids[5], 32'h15, 32'h25);
    n = 0;
    while (rpt_q.size() < 6 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rpt_count", rpt_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      r = (i < rpt_q.size()) ? rpt_q[i] : 3'bxxx;
      chk("bp_order", r, {1'b0, bp_ids[i]});
    end

    // Reset during POLL_WAIT
    log_q.delete();
    rpt_q.delete();
    s_done_after = 0;
    s_delay_max  = 0;
    push(2'd3, 32'hAA, 32'hBB);
    n = 0;
    while (log_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_start_seen", log_q.size(), 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_idle", {bus.m_cyc_o, bus.m_stb_o, busy, job_ready},
        4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mrst_no_rpt", rpt_q.size(), 0);
    chk("mrst_no_bus", log_q.size(), 3);
    run_vec(vecs[0]);

    chk("bus_protocol_viol", bus_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
